// File: rtl/fip_32_alu_arbiter.sv
// Round-robin front end that shares the Q16.16 add/sub/mult/div datapath among N_REQ requesters
// and returns each tagged result over a valid/ready response channel.
module fip_32_alu_arbiter #(
    parameter int N_REQ      = 4,
    parameter int INT_SHIFT  = 16,
    parameter int DIV_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [32*N_REQ-1:0]      req_x,
    input  logic [32*N_REQ-1:0]      req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_data,
    output logic                     rsp_ovf,
    output logic                     rsp_unf
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_code;
    logic signed [31:0] op_x;
    logic signed [31:0] op_y;
    logic [IDW-1:0]     op_id;

    logic [IDW:0]       cand;
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [1:0]         grant_op;

    logic [31:0]        add_res;
    logic [31:0]        sub_res;
    logic               add_ovf;
    logic               sub_ovf;
    logic signed [63:0] mul_full;
    logic signed [63:0] mul_shift;
    logic signed [63:0] div_num;
    logic signed [63:0] div_den;
    logic signed [63:0] div_q;
    logic               mul_ovf;
    logic               div_ovf;
    logic               div_unf;
    logic [31:0]        sel_data;
    logic               sel_ovf;
    logic               sel_unf;

    // First requesting index at or after ptr, wrapping around the requester set.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ))
                cand = cand - (IDW+1)'(N_REQ);
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found)
            req_ready = N_REQ'(1) << grant_idx;
    end

    assign grant_op = req_op[2*grant_idx +: 2];

    // Arithmetic units, fed only from the captured operand registers.
    always_comb begin
        add_res   = op_x + op_y;
        add_ovf   = (op_x[31] == op_y[31]) && (add_res[31] != op_x[31]);
        sub_res   = op_x - op_y;
        sub_ovf   = (op_x[31] != op_y[31]) && (sub_res[31] != op_x[31]);
        mul_full  = $signed({{32{op_x[31]}}, op_x}) * $signed({{32{op_y[31]}}, op_y});
        mul_shift = mul_full >>> INT_SHIFT;
        mul_ovf   = !((&mul_shift[63:31]) || !(|mul_shift[63:31]));
        div_num   = $signed({{32{op_x[31]}}, op_x}) <<< INT_SHIFT;
        div_den   = (op_y == 32'sd0) ? 64'sd1 : $signed({{32{op_y[31]}}, op_y});
        div_q     = div_num / div_den;
        div_ovf   = !((&div_q[63:31]) || !(|div_q[63:31]));
        div_unf   = (div_q == 64'sd0) && (op_x != 32'sd0);
    end

    always_comb begin
        sel_data = add_res;
        sel_ovf  = add_ovf;
        sel_unf  = 1'b0;
        case (op_code)
            2'b00: begin sel_data = add_res; sel_ovf = add_ovf; end
            2'b01: begin sel_data = sub_res; sel_ovf = sub_ovf; end
            2'b10: begin sel_data = mul_shift[31:0]; sel_ovf = mul_ovf; end
            default: begin
                if (op_y == 32'sd0) begin
                    sel_data = op_x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    sel_ovf  = 1'b1;
                end else begin
                    sel_data = div_q[31:0];
                    sel_ovf  = div_ovf;
                    sel_unf  = div_unf;
                end
            end
        endcase
    end

    // Operands stay frozen from capture until RESP; the divider relies on this as a multicycle path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            op_code   <= '0;
            op_x      <= '0;
            op_y      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_unf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_code <= grant_op;
                        op_x    <= req_x[32*grant_idx +: 32];
                        op_y    <= req_y[32*grant_idx +: 32];
                        op_id   <= grant_idx;
                        ptr     <= (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                        cnt     <= (grant_op == 2'b11) ? CW'(DIV_CYCLES-1) : '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id;
                        rsp_data  <= sel_data;
                        rsp_ovf   <= sel_ovf;
                        rsp_unf   <= sel_unf;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fip_32_alu_arbiter.md
# fip_32_alu_arbiter

Shared-access controller for the Q16.16 fixed-point arithmetic units: fip_32_adder, fip_32_sub, fip_32_mult and fip_32_div. It accepts operation requests from N_REQ requesters, such as ray-intersection and shading stages, and grants one at a time by round-robin. It holds the operands stable for the required number of cycles, which gives the divider a multicycle path. It returns the registered result, tagged with the requester index, over a valid/ready response channel.

## Interface
- N_REQ, 4, number of requesters (2..8)
- INT_SHIFT, 16, fractional bits; informational, must match the arithmetic units
- DIV_CYCLES, 4, EXEC cycles for a divide (≥1); add/sub/mult always take 1
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- req_op  input  2*N_REQ  per-requester op: 00 add, 01 sub, 10 mult, 11 div
- req_x  input  32*N_REQ  per-requester signed Q16.16 operand x / dividend
- req_y  input  32*N_REQ  per-requester signed Q16.16 operand y / divisor
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  clog2(N_REQ)  index of the requester being answered
- rsp_data  output  32  signed Q16.16 result
- rsp_ovf  output  1  overflow flag from the selected unit
- rsp_unf  output  1  underflow flag (divide only; 0 for other ops)

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If any req_valid is set, grant index g: the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - req_ready[g] is 1 combinationally in this cycle only.
  - On the clock edge, capture op, x, y and id=g into internal registers, and set ptr = (g+1) mod N_REQ.
  - Go to EXEC with cnt = (op==div) ? DIV_CYCLES-1 : 0.
- **req_ready:** all bits are 0 in EXEC and RESP.
- **EXEC:**
  - The captured registers drive all four units and stay constant for the whole state.
  - If cnt≠0, decrement cnt.
  - If cnt==0, select the result by op into the rsp_* registers and go to RESP.
- **RESP:**
  - rsp_valid=1. rsp_id, rsp_data, rsp_ovf and rsp_unf stay stable until the handshake.
  - When rsp_valid && rsp_ready, go to IDLE. There is no grant in the same cycle.
- **Divide by zero** (op==div, y==0): the unit output is ignored.
  - rsp_data = 0x7FFFFFFF if x≥0, otherwise 0x80000000.
  - rsp_ovf=1, rsp_unf=0.
- **Width rules:** results and flags are passed through from the units unchanged, with no extra saturation except the divide-by-zero case. rsp_unf is forced to 0 for add, sub and mult.
- **Requester obligations:** hold req_valid, req_op, req_x and req_y stable until req_ready. Dropping req_valid before the grant is permitted and simply withdraws the request.
- **Reset at any time:**
  - FSM returns to IDLE and ptr=0.
  - The in-flight operation is discarded; no response is issued.

## Timing
- **Reset values:** req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, rsp_unf=0, ptr=0.
- **Latency:**
  - Let acceptance occur at edge e0 (req_valid && req_ready).
  - rsp_valid rises after edge eL, where L=1 for add/sub/mult and L=DIV_CYCLES for div.
- **Minimum spacing between grants:** L+2 cycles, when rsp_ready is held high.
- **Backpressure:** rsp_ready low holds RESP indefinitely. Requests wait; none are lost or reordered per requester.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Fairness is round-robin: a continuously requesting index is served within N_REQ grants.
- **Single active requester:** repeated grants to the same index are legal (ptr wraps).

## Test plan
- **Single add:** req 0, add, x=0x00010000, y=0x00010000.
  - Expect req_ready[0] for 1 cycle.
  - Expect rsp_valid after 1 edge with rsp_id=0, data=0x00020000, ovf=0.
- **Contention:** all 4 requesters valid with mult 0x00008000×0x00008000, rsp_ready=1.
  - Expect grants in order 0,1,2,3,0.
  - Expect each response data=0x00004000, with rsp_id matching the grant.
- **Divide latency:** DIV_CYCLES=4, req 2, div, x=0x00020000, y=0x00020000.
  - Expect rsp_valid exactly 4 edges after acceptance, data=0x00010000, id=2.
  - Expect operand registers constant during EXEC.
- **Overflow and divide-by-zero:**
  - add x=0x7FFFFFFF, y=0x00010000: expect ovf=1.
  - sub x=0x80000000, y=1: expect ovf=1.
  - div x=0xFFFF0000, y=0: expect data=0x80000000, ovf=1, unf=0.
- **Backpressure:** hold rsp_ready=0 for 10 cycles during RESP.
  - Expect rsp_* stable and req_ready all 0.
  - On release, expect handshake, then next grant one cycle after IDLE is re-entered.
- **Reset mid-op:** assert rst_n=0 during div EXEC cycle 2.
  - Expect all outputs to reset values immediately.
  - After release, expect no stale response and next grant from index 0.
